// File: rtl/traffic_signal_ctrl_param.sv
// Highway/country-road signal controller with per-phase cycle timer, min highway green,
// max country green and a latched pedestrian request served with a walk lamp.
// Latency: lamps decode the registered state; requests act on the next posedge. No backpressure.
module traffic_signal_ctrl_param #(
    parameter int CNT_W         = 8,
    parameter int Y2R_CYC       = 3,
    parameter int R2G_CYC       = 2,
    parameter int MIN_HWY_GRN   = 4,
    parameter int MAX_CNTRY_GRN = 8,
    parameter int PED_WALK      = 5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [1:0] LAMP_RED = 2'd0;
    localparam logic [1:0] LAMP_YEL = 2'd1;
    localparam logic [1:0] LAMP_GRN = 2'd2;

    // Timer values on the last cycle of each phase (a phase of N cycles ends at N-1).
    localparam logic [CNT_W-1:0] Y2R_LAST   = CNT_W'(Y2R_CYC - 1);
    localparam logic [CNT_W-1:0] R2G_LAST   = CNT_W'(R2G_CYC - 1);
    localparam logic [CNT_W-1:0] HWY_MIN_LAST = CNT_W'(MIN_HWY_GRN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX_LAST = CNT_W'(MAX_CNTRY_GRN - 1);
    localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_WALK - 1);
    localparam logic [CNT_W-1:0] TMR_SAT    = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;
    logic             r_walk_act;

    state_t           w_nxt;
    logic [CNT_W-1:0] w_min_last;
    logic             w_enter_s3;
    logic             w_exit_s4;

    // Next-state selection; x is only looked at in S0 and S3.
    always_comb begin
        w_nxt      = r_state;
        w_min_last = r_walk_act ? PED_LAST : '0;
        case (r_state)
            S0: if ((r_timer >= HWY_MIN_LAST) && (x || r_ped_pend)) w_nxt = S1;
            S1: if (r_timer == Y2R_LAST) w_nxt = S2;
            S2: if (r_timer == R2G_LAST) w_nxt = S3;
            S3: if ((r_timer == CNT_MAX_LAST) || (!x && (r_timer >= w_min_last))) w_nxt = S4;
            S4: if (r_timer == Y2R_LAST) w_nxt = S0;
            default: w_nxt = S0;
        endcase
        w_enter_s3 = (r_state != S3) && (w_nxt == S3);
        w_exit_s4  = (r_state == S4) && (w_nxt == S0);
    end

    // State, phase timer and pedestrian bookkeeping; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S0;
            r_timer    <= '0;
            r_ped_pend <= 1'b0;
            r_walk_act <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state)
                r_timer <= '0;
            else if (r_timer != TMR_SAT)
                r_timer <= r_timer + 1'b1;

            // A press landing on the S3 entry edge is served in this round, not lost.
            if (w_enter_s3)
                r_ped_pend <= 1'b0;
            else if (ped_req)
                r_ped_pend <= 1'b1;

            if (w_enter_s3)
                r_walk_act <= r_ped_pend | ped_req;
            else if (w_exit_s4)
                r_walk_act <= 1'b0;
        end
    end

    // Lamp decode from the registered state; illegal codes show the S0 lamps.
    always_comb begin
        hwy     = LAMP_GRN;
        cntry   = LAMP_RED;
        walk    = 1'b0;
        state_o = r_state;
        case (r_state)
            S1: begin
                hwy   = LAMP_YEL;
                cntry = LAMP_RED;
            end
            S2: begin
                hwy   = LAMP_RED;
                cntry = LAMP_RED;
            end
            S3: begin
                hwy   = LAMP_RED;
                cntry = LAMP_GRN;
                walk  = r_walk_act;
            end
            S4: begin
                hwy   = LAMP_RED;
                cntry = LAMP_YEL;
            end
            default: begin
                hwy   = LAMP_GRN;
                cntry = LAMP_RED;
            end
        endcase
    end

endmodule
